bus_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one slave bus (typically the RAM/peripheral decode path behind the CPU) between master 0 (CPU) and master 1 (DMA or debug port). It uses the standard valid/ready word-bus protocol: fields are held stable while valid is high, and a transfer completes on the cycle valid and ready are both high. A per-transaction watchdog aborts accesses that never complete. It reports the abort through a one-cycle error pulse.

---
 rtl/bus_arbiter.sv | 134 +++++++++++++
 tb/tb_bus_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with per-transfer watchdog onto one valid/ready slave bus.
// Latency: one IDLE arbitration cycle, then s_* and the granted master's ready/rdata are combinational.
// Backpressure: s_ready stalls the granted master; the watchdog aborts after TIMEOUT_CYCLES busy cycles.
module bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERROR_RDATA    = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic [31:0] m0_address,
   input  logic [3:0]  m0_wstrobe,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic        m1_valid,
   input  logic [31:0] m1_address,
   input  logic [3:0]  m1_wstrobe,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic        s_valid,
   output logic [31:0] s_address,
   output logic [3:0]  s_wstrobe,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,
   output logic [1:0]  grant,
   output logic        timeout_error,
   output logic        error_master
);

   // A zero timeout still needs a 1-bit counter so the design elaborates.
   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic WD_EN = (TIMEOUT_CYCLES != 0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY0 = 2'd1;
   localparam logic [1:0] ST_BUSY1 = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              prio_q, prio_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_master_q, err_master_d;

   logic        busy0, busy1;
   logic        own_valid;
   logic        xfer_done;
   logic        abort;
   logic        finish;
   logic [31:0] resp_rdata;

   // Datapath muxing: forward the owner's request, route the response back to the owner only.
   always_comb begin
      busy0      = (state_q == ST_BUSY0);
      busy1      = (state_q == ST_BUSY1);
      own_valid  = busy0 ? m0_valid : (busy1 ? m1_valid : 1'b0);
      xfer_done  = own_valid & s_ready;
      // Abort only a live request; a dropped valid is handled as a plain return to idle.
      abort      = WD_EN & own_valid & ~s_ready & (wait_q == WAIT_LAST);
      finish     = xfer_done | abort;
      resp_rdata = abort ? ERROR_RDATA : s_rdata;

      s_valid    = own_valid;
      s_address  = busy0 ? m0_address : (busy1 ? m1_address : 32'h0);
      s_wstrobe  = busy0 ? m0_wstrobe : (busy1 ? m1_wstrobe : 4'h0);
      s_wdata    = busy0 ? m0_wdata   : (busy1 ? m1_wdata   : 32'h0);

      m0_ready   = busy0 & finish;
      m1_ready   = busy1 & finish;
      m0_rdata   = busy0 ? resp_rdata : 32'h0;
      m1_rdata   = busy1 ? resp_rdata : 32'h0;

      grant         = {busy1, busy0};
      timeout_error = abort;
      error_master  = err_master_q;
   end

   // Next-state: arbitrate in IDLE, otherwise wait for completion, abort or a dropped request.
   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      wait_d       = wait_q;
      err_master_d = err_master_q;
      case (state_q)
         ST_IDLE: begin
            // Keeping the counter cleared in IDLE means every grant starts from zero.
            wait_d = '0;
            if (m0_valid && m1_valid) begin
               state_d = prio_q ? ST_BUSY1 : ST_BUSY0;
            end else if (m0_valid) begin
               state_d = ST_BUSY0;
            end else if (m1_valid) begin
               state_d = ST_BUSY1;
            end
         end
         ST_BUSY0, ST_BUSY1: begin
            if (!own_valid) begin
               // Master withdrew: no ready, priority left as it was.
               state_d = ST_IDLE;
            end else if (finish) begin
               state_d = ST_IDLE;
               prio_d  = busy0;          // hand preference to the other master
               if (abort) begin
                  err_master_d = busy1;
               end
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers, cleared asynchronously so a reset drops any transfer in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         prio_q       <= 1'b0;
         wait_q       <= '0;
         err_master_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         wait_q       <= wait_d;
         err_master_q <= err_master_d;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: arbitration order, stalls, watchdog abort and async reset.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
// Every loop has a fixed length, so the run always reaches its summary.
module tb_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        m0_valid, m1_valid;
   logic [31:0] m0_address, m1_address;
   logic [3:0]  m0_wstrobe, m1_wstrobe;
   logic [31:0] m0_wdata, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ready, m1_ready;
   logic        s_valid;
   logic [31:0] s_address;
   logic [3:0]  s_wstrobe;
   logic [31:0] s_wdata;
   logic [31:0] s_rdata;
   logic        s_ready;
   logic [1:0]  grant;
   logic        timeout_error;
   logic        error_master;

   int n_cmp;
   int n_bad;

   bus_arbiter #(.TIMEOUT_CYCLES(16), .ERROR_RDATA(32'hDEADBEEF)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_address(m0_address), .m0_wstrobe(m0_wstrobe),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m1_valid(m1_valid), .m1_address(m1_address), .m1_wstrobe(m1_wstrobe),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .s_valid(s_valid), .s_address(s_address), .s_wstrobe(s_wstrobe),
      .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready),
      .grant(grant), .timeout_error(timeout_error), .error_master(error_master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One granted transfer against a stalled slave; optionally s_ready arrives on the 16th busy cycle.
   task automatic run_wd(input int k, input bit late_ready, input logic exp_err_master);
      logic        last;
      logic        rdy;
      logic [31:0] rd;
      m0_valid = (k == 0);
      m1_valid = (k == 1);
      s_ready  = 1'b0;
      s_rdata  = 32'h5555_0000 + 32'(k);
      #1;
      check_val("wd_idle_grant", {30'b0, grant}, 32'd0);
      tick();
      for (int i = 1; i <= 16; i++) begin
         last    = (i == 16);
         s_ready = late_ready & last;
         #1;
         rdy = (k == 1) ? m1_ready : m0_ready;
         rd  = (k == 1) ? m1_rdata : m0_rdata;
         check_val("wd_grant", {30'b0, grant}, (k == 1) ? 32'd2 : 32'd1);
         check_val("wd_ready", {31'b0, rdy}, {31'b0, last});
         check_val("wd_terr", {31'b0, timeout_error}, {31'b0, last & ~late_ready});
         check_val("wd_rdata", rd, (last && !late_ready) ? 32'hDEADBEEF : s_rdata);
         tick();
      end
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      s_ready  = 1'b0;
      #1;
      check_val("wd_after_grant", {30'b0, grant}, 32'd0);
      check_val("wd_after_terr", {31'b0, timeout_error}, 32'd0);
      check_val("wd_err_master", {31'b0, error_master}, {31'b0, exp_err_master});
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      m0_valid = 1'b0; m0_address = '0; m0_wstrobe = '0; m0_wdata = '0;
      m1_valid = 1'b0; m1_address = '0; m1_wstrobe = '0; m1_wdata = '0;
      s_rdata = '0; s_ready = 1'b0;

      // Reset state
      #12;
      check_val("rst_s_valid", {31'b0, s_valid}, 32'd0);
      check_val("rst_grant", {30'b0, grant}, 32'd0);
      check_val("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
      check_val("rst_terr", {31'b0, timeout_error}, 32'd0);
      check_val("rst_err_master", {31'b0, error_master}, 32'd0);
      check_val("rst_s_address", s_address, 32'd0);
      reset = 1'b0;

      // Single m0 read against a zero-wait slave
      m0_valid = 1'b1; m0_address = 32'h0000_0010;
      #1;
      check_val("t1_idle_s_valid", {31'b0, s_valid}, 32'd0);
      check_val("t1_idle_grant", {30'b0, grant}, 32'd0);
      tick();
      s_ready = 1'b1; s_rdata = 32'hCAFE_0010;
      #1;
      check_val("t1_s_valid", {31'b0, s_valid}, 32'd1);
      check_val("t1_s_address", s_address, 32'h0000_0010);
      check_val("t1_m0_ready", {31'b0, m0_ready}, 32'd1);
      check_val("t1_m0_rdata", m0_rdata, 32'hCAFE_0010);
      check_val("t1_m1_rdata", m1_rdata, 32'd0);
      check_val("t1_grant", {30'b0, grant}, 32'd1);
      tick();
      m0_valid = 1'b0; s_ready = 1'b0;
      #1;
      check_val("t1_end_grant", {30'b0, grant}, 32'd0);

      // Both masters requesting after reset: strict alternation starting with m0
      reset = 1'b1;
      #2;
      reset = 1'b0;
      m0_valid = 1'b1; m0_address = 32'h0000_0100;
      m1_valid = 1'b1; m1_address = 32'h0000_0200;
      s_ready = 1'b1; s_rdata = 32'hA5A5_0000;
      for (int r = 0; r < 2; r++) begin
         #1;
         check_val("t2_idle0_grant", {30'b0, grant}, 32'd0);
         tick();
         #1;
         check_val("t2_m0_grant", {30'b0, grant}, 32'd1);
         check_val("t2_m0_addr", s_address, 32'h0000_0100);
         check_val("t2_m0_ready", {31'b0, m0_ready}, 32'd1);
         check_val("t2_m1_idle_ready", {31'b0, m1_ready}, 32'd0);
         tick();
         #1;
         check_val("t2_idle1_grant", {30'b0, grant}, 32'd0);
         tick();
         #1;
         check_val("t2_m1_grant", {30'b0, grant}, 32'd2);
         check_val("t2_m1_addr", s_address, 32'h0000_0200);
         check_val("t2_m1_ready", {31'b0, m1_ready}, 32'd1);
         check_val("t2_m1_rdata", m1_rdata, 32'hA5A5_0000);
         check_val("t2_m0_idle_ready", {31'b0, m0_ready}, 32'd0);
         tick();
      end
      m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;

      // m1 write held through a 3-cycle slave stall
      m1_valid = 1'b1; m1_address = 32'h0000_0300;
      m1_wstrobe = 4'hF; m1_wdata = 32'h1234_5678;
      #1;
      check_val("t3_idle_grant", {30'b0, grant}, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         s_ready = (i == 3);
         #1;
         check_val("t3_wdata", s_wdata, 32'h1234_5678);
         check_val("t3_wstrobe", {28'b0, s_wstrobe}, 32'hF);
         check_val("t3_m1_ready", {31'b0, m1_ready}, (i == 3) ? 32'd1 : 32'd0);
         check_val("t3_m0_ready", {31'b0, m0_ready}, 32'd0);
         check_val("t3_m0_rdata", m0_rdata, 32'd0);
         tick();
      end
      m1_valid = 1'b0; s_ready = 1'b0; m1_wstrobe = 4'h0;

      // Watchdog: m0 abort, m1 abort, then m0 rescued by s_ready on the last cycle
      run_wd(0, 1'b0, 1'b0);
      run_wd(1, 1'b0, 1'b1);
      run_wd(0, 1'b1, 1'b1);

      // Async reset while m1 is stalled; priority (m1 preferred before) returns to m0
      m1_valid = 1'b1;
      #1;
      tick();
      #1;
      check_val("t6_busy_grant", {30'b0, grant}, 32'd2);
      check_val("t6_busy_s_valid", {31'b0, s_valid}, 32'd1);
      tick();
      reset = 1'b1;
      #1;
      check_val("t6_rst_s_valid", {31'b0, s_valid}, 32'd0);
      check_val("t6_rst_m1_ready", {31'b0, m1_ready}, 32'd0);
      check_val("t6_rst_grant", {30'b0, grant}, 32'd0);
      check_val("t6_rst_err_master", {31'b0, error_master}, 32'd0);
      #1;
      reset = 1'b0;
      m0_valid = 1'b1; m1_valid = 1'b1;
      #1;
      check_val("t6_idle_grant", {30'b0, grant}, 32'd0);
      tick();
      #1;
      check_val("t6_m0_wins", {30'b0, grant}, 32'd1);
      check_val("t6_s_address", s_address, 32'h0000_0100);
      m0_valid = 1'b0; m1_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
